// File: rtl/mdu.sv
`default_nettype none
// ---- mdu : iterative RV32M multiply/divide unit (shift-add / restoring) ----
// ---- rev 1.0 ----------------------------------------------------------------
module mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            we_o,
  output logic [4:0]      wa_o,
  output logic [XLEN-1:0] wd_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] bmag_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic            busy_q;
  logic            done_q;
  logic            we_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] wd_q;

  // Operand sign handling at accept time: only magnitudes enter the datapath.
  logic            a_signed_in;
  logic            b_signed_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic [XLEN-1:0] amag_in;
  logic [XLEN-1:0] bmag_in;

  always_comb begin
    a_signed_in = (funct3_i == OP_MUL) || (funct3_i == OP_MULH) || (funct3_i == OP_MULHSU) ||
                  (funct3_i == OP_DIV) || (funct3_i == OP_REM);
    b_signed_in = (funct3_i == OP_MUL) || (funct3_i == OP_MULH) ||
                  (funct3_i == OP_DIV) || (funct3_i == OP_REM);
    a_neg_in    = a_signed_in & a_i[XLEN-1];
    b_neg_in    = b_signed_in & b_i[XLEN-1];
    amag_in     = a_neg_in ? (~a_i + 1'b1) : a_i;
    bmag_in     = b_neg_in ? (~b_i + 1'b1) : b_i;
  end

  // One iteration: {acc,lo} is the product register for multiply and the
  // {remainder,quotient/dividend} pair for divide.
  logic            is_div;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shl;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] lo_d;

  always_comb begin
    is_div   = op_q[2];
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, bmag_q} : {(XLEN+1){1'b0}});
    div_shl  = {acc_q, lo_q[XLEN-1]};
    div_diff = {1'b0, div_shl} - {2'b00, bmag_q};
    div_ge   = ~div_diff[XLEN+1];
    if (is_div) begin
      acc_d = div_ge ? div_diff[XLEN-1:0] : div_shl[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s;
  logic [XLEN-1:0]   rem_s;
  logic              b_zero;
  logic              ovf;
  logic [XLEN-1:0]   wd_d;

  always_comb begin
    prod_mag = {acc_q, lo_q};
    prod_s   = (a_neg_q ^ b_neg_q) ? (~prod_mag + 1'b1) : prod_mag;
    quot_s   = (a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q;
    rem_s    = a_neg_q ? (~acc_q + 1'b1) : acc_q;
    b_zero   = (bmag_q == '0);
    // -1 divisor is the only signed value whose magnitude is 1 with the sign bit set
    ovf      = (a_q == MIN_NEG) && b_neg_q && (bmag_q == XLEN'(1));
    case (op_q)
      OP_MUL:    wd_d = prod_s[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  wd_d = prod_s[2*XLEN-1:XLEN];
      OP_DIV:    wd_d = b_zero ? '1 : (ovf ? MIN_NEG : quot_s);
      OP_DIVU:   wd_d = b_zero ? '1 : lo_q;
      OP_REM:    wd_d = b_zero ? a_q : (ovf ? '0 : rem_s);
      OP_REMU:   wd_d = b_zero ? a_q : acc_q;
      default:   wd_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      bmag_q  <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q    <= funct3_i;
            rd_q    <= rd_i;
            a_q     <= a_i;
            bmag_q  <= bmag_in;
            a_neg_q <= a_neg_in;
            b_neg_q <= b_neg_in;
            acc_q   <= '0;
            lo_q    <= amag_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          wd_q    <= wd_d;
          wa_q    <= rd_q;
          done_q  <= 1'b1;
          we_q    <= (rd_q != 5'd0);
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign we_o   = we_q;
  assign wa_o   = wa_q;
  assign wd_o   = wd_q;

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Iterative RV32M multiply/divide unit for the single-cycle core. Sits between the register file and its write port. It takes both source operands (RD1/RD2), rd and funct3 from decode. It returns a 32-bit result with a write strobe to the register-file write port after a fixed multi-cycle latency. While it works, it holds `busy` so the core can stall.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported and verified.
- `clk`  in  1  system clock; rising edge active.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to begin an operation. Sampled only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand (from RD1).
- `b`  in  XLEN  rs2 operand (from RD2).
- `rd`  in  5  destination register index.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle result-valid pulse.
- `we`  out  1  register-file write enable; equals `done & (wa != 0)`.
- `wa`  out  5  destination index of the result.
- `wd`  out  XLEN  result data.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If `start`=1, latch `funct3`, `rd`, `a`, `b`; clear the iteration counter; go to CALC.
  - If `start`=0, stay in IDLE.
- **CALC:** 32 cycles, one iteration per edge. A 5-bit counter runs 0..31; at count 31, go to FIX.
  - Multiply: radix-2 shift-add on operand magnitudes, giving a 64-bit unsigned product.
    - MUL and MULH: both operands are signed.
    - MULHSU: `a` is signed, `b` is unsigned.
    - MULHU: both operands are unsigned.
  - Divide: restoring division on magnitudes, giving a 32-bit quotient and remainder.
    - DIV and REM: both operands are signed.
    - DIVU and REMU: both operands are unsigned.
- **FIX:** apply sign correction, select the result, register `wd` and `wa`, then go to DONE.
  - Product: negate if the operand signs differ.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
  - Quotient: negate if the signs differ (DIV only).
  - Remainder: takes the dividend's sign (REM only).
- **DONE:** `done`=1 for exactly one cycle; `we` per its definition; next state is IDLE.
- Special results, forced in FIX; latency is unchanged:
  - Divisor 0:
    - DIV and DIVU give 0xFFFFFFFF.
    - REM and REMU give `a`.
  - Signed overflow (`a`=0x80000000, `b`=0xFFFFFFFF):
    - DIV gives 0x80000000.
    - REM gives 0.
- `start` while busy (CALC, FIX or DONE) is ignored: no queuing and no operand re-latch.
- `rd`=0: the operation executes and `done` pulses, but `we` stays 0.
- `wd` and `wa` hold the last result until the next FIX.

## Timing
- Reset: `rst`=0 forces IDLE immediately and asynchronously, including mid-operation.
  - `busy`, `done`, `we`, `wa`, `wd` and all internal operand, accumulator and counter registers go to 0.
  - After reset is released, the next accepted `start` behaves normally.
- Latency is fixed for every funct3 and operand value. With edge E0 being the one that samples `start`=1 in IDLE:
  - E1..E32 are CALC iterations.
  - E33 is FIX.
  - `done`, `we`, `wd` and `wa` are valid in the cycle after E33 and are sampled by the register file at E34.
  - At E34 the FSM returns to IDLE.
- `busy` rises after E0 and falls after E34.
  - A new `start` presented in the cycle after E34 is accepted.
  - Back-to-back operations therefore occur at most every 35 cycles.
- Operands `a`, `b`, `rd` and `funct3` may change freely after E0.
- No combinational path exists from any input to any output.

## Test plan
- MUL `a`=7, `b`=0xFFFFFFFD, `rd`=5 -> `done` and `we` high exactly in the cycle after E33, `wa`=5, `wd`=0xFFFFFFEB; `busy` high for 34 cycles.
- High-half products:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 % 7 -> 2.
- Corner cases:
  - DIV 5/0 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - All complete with identical latency.
- Busy and zero-destination handling:
  - Pulse `start` with new operands during CALC -> ignored; the result matches the first operands and only one `done` pulse occurs.
  - An op with `rd`=0 -> `done`=1, `we`=0.
- Drive `rst`=0 at the 10th CALC cycle -> all outputs 0 immediately and no `done` pulse. After release, a fresh MULU-class op (MULHU 2 x 3) -> `wd`=0 with the correct 34-cycle latency.
